// File: rtl/bp_io_cce_sched.sv
// bp_io_cce_sched: shares one uncached I/O command channel among num_req_p
// requesters and routes I/O responses back to the requester that issued them.
//   req_i/req_v_i/req_yumi_o : per-requester command sources (slice i = requester i)
//   io_cmd_*                 : one-entry registered command stage, valid/ready
//   io_resp_*                : response input, consumed when the target is ready
//   resp_o/resp_v_o          : response broadcast plus one-hot valid
//   resp_ready_i             : per-requester response ready
//   credit_empty_o           : requester has nothing outstanding
//   err_o                    : sticky; credit underflow or bad response source

// Per-requester outstanding-command counter.
module bp_io_cce_sched_credit #(
  parameter int max_outstanding_p = 4,
  parameter int cnt_width_p       = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic eligible_o,
  output logic empty_o,
  output logic underflow_o
);
  localparam logic [cnt_width_p-1:0] MaxCnt = cnt_width_p'(max_outstanding_p);

  logic [cnt_width_p-1:0] cnt_q, cnt_d;

  // A grant and a response in the same cycle cancel. A response with no
  // credit in flight saturates at zero and is reported as an underflow.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i)                        cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i && cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;

  assign eligible_o  = (cnt_q < MaxCnt);
  assign empty_o     = (cnt_q == '0);
  assign underflow_o = dec_i & ~inc_i & (cnt_q == '0);
endmodule

module bp_io_cce_sched #(
  parameter int num_req_p         = 4,
  parameter int msg_width_p       = 128,
  parameter int max_outstanding_p = 4,
  parameter int req_id_width_p    = 2,
  parameter int cnt_width_p       = 3
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p*msg_width_p-1:0] req_i,
  input  logic [num_req_p-1:0]             req_v_i,
  output logic [num_req_p-1:0]             req_yumi_o,
  output logic [msg_width_p-1:0]           io_cmd_o,
  output logic [req_id_width_p-1:0]        io_cmd_src_o,
  output logic                             io_cmd_v_o,
  input  logic                             io_cmd_ready_i,
  input  logic [msg_width_p-1:0]           io_resp_i,
  input  logic [req_id_width_p-1:0]        io_resp_src_i,
  input  logic                             io_resp_v_i,
  output logic                             io_resp_yumi_o,
  output logic [msg_width_p-1:0]           resp_o,
  output logic [num_req_p-1:0]             resp_v_o,
  input  logic [num_req_p-1:0]             resp_ready_i,
  output logic [num_req_p-1:0]             credit_empty_o,
  output logic                             err_o
);
  typedef enum logic {ST_EMPTY, ST_FULL} stage_e;

  stage_e                      state_q, state_d;
  logic [msg_width_p-1:0]      cmd_q, cmd_d;
  logic [req_id_width_p-1:0]   src_q, src_d;
  logic [req_id_width_p-1:0]   rr_q, rr_d;
  logic                        err_q, err_d;

  logic [num_req_p-1:0] elig, credit_ok, dec, underflow;
  logic [req_id_width_p-1:0] win;
  logic found, grant, src_ok;

  genvar g;
  for (g = 0; g < num_req_p; g++) begin : g_req
    bp_io_cce_sched_credit #(
      .max_outstanding_p(max_outstanding_p),
      .cnt_width_p      (cnt_width_p)
    ) u_credit (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .inc_i      (req_yumi_o[g]),
      .dec_i      (dec[g]),
      .eligible_o (credit_ok[g]),
      .empty_o    (credit_empty_o[g]),
      .underflow_o(underflow[g])
    );
    assign elig[g]       = req_v_i[g] & credit_ok[g];
    assign req_yumi_o[g] = grant && (win == req_id_width_p'(g));
    assign resp_v_o[g]   = io_resp_v_i && src_ok && (io_resp_src_i == req_id_width_p'(g));
    assign dec[g]        = resp_v_o[g] & resp_ready_i[g];
  end

  // Round-robin: first eligible requester at or after rr_q, wrapping.
  always_comb begin
    logic [req_id_width_p-1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = req_id_width_p'((int'(rr_q) + k) % num_req_p);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // A full stage that drains this cycle can be refilled in the same cycle.
  assign grant = found && (state_q == ST_EMPTY || io_cmd_ready_i) && !reset_i;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    src_d   = src_q;
    rr_d    = rr_q;
    if (grant) begin
      state_d = ST_FULL;
      cmd_d   = req_i[win*msg_width_p +: msg_width_p];
      src_d   = win;
      rr_d    = (win == req_id_width_p'(num_req_p - 1)) ? '0 : win + 1'b1;
    end else if (state_q == ST_FULL && io_cmd_ready_i) begin
      state_d = ST_EMPTY;
    end
  end

  assign src_ok = (32'(io_resp_src_i) < 32'(num_req_p));
  assign err_d  = err_q | (|underflow) | (io_resp_v_i & ~src_ok);

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= ST_EMPTY;
      cmd_q   <= '0;
      src_q   <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end

  assign io_cmd_v_o     = (state_q == ST_FULL);
  assign io_cmd_o       = cmd_q;
  assign io_cmd_src_o   = src_q;
  assign io_resp_yumi_o = |dec;
  assign resp_o         = io_resp_i;
  assign err_o          = err_q;
endmodule
